dmem_responder: RTL and testbench

- Data-memory responder: the target end of the core's load/store memory interface.
- Accepts one request at a time from the core's load/store path over a valid/ready request channel.
- Performs byte, halfword and word accesses with RV32 load extension, and returns data or an error after a fixed configurable latency over a valid/ready response channel.
- Replaces the always-ready single-cycle data memory; the core stalls on req_ready/rsp_valid.

---
 rtl/dmem_responder.sv | 183 ++++++++++++++++++
 tb/tb_dmem_responder.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: single-outstanding load/store target with fixed response latency,
// byte/half/word lanes and RV32 load extension over valid/ready request and response channels.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          AW         = $clog2(DEPTH_WORDS);
  localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  CNT_LOAD   = 4'(LATENCY - 1);
  localparam logic        LAT_ONE    = (LATENCY == 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [3:0]  cnt;
  logic        accept;
  logic        enter_resp;

  logic [31:0] mem [DEPTH_WORDS];

  logic        wr_p0;
  logic [31:0] addr_p0;
  logic [1:0]  size_p0;
  logic        uns_p0;

  logic        req_err;
  logic [3:0]  wr_lanes;
  logic [31:0] wr_data;

  logic        sel_wr;
  logic [31:0] sel_addr;
  logic [1:0]  sel_size;
  logic        sel_uns;
  logic        sel_err;
  logic [31:0] rd_word;

  function automatic logic check_err(input logic [31:0] a, input logic [1:0] s);
    logic e;
    e = ({1'b0, a} >= ADDR_LIMIT);
    case (s)
      2'd1:    e = e | a[0];
      2'd2:    e = e | (a[1:0] != 2'b00);
      2'd3:    e = 1'b1;
      default: e = e;
    endcase
    return e;
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] off, input logic [1:0] s);
    case (s)
      2'd0:    return 4'b0001 << off;
      2'd1:    return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Store data is right-aligned; replicate it so every candidate lane carries it.
  function automatic logic [31:0] lane_data(input logic [31:0] wd, input logic [1:0] s);
    case (s)
      2'd0:    return {4{wd[7:0]}};
      2'd1:    return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] w, input logic [1:0] off,
                                              input logic [1:0] s, input logic u);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (s)
      2'd0:    return u ? {24'd0, b} : {{24{b[7]}}, b};
      2'd1:    return u ? {16'd0, h} : {{16{h[15]}}, h};
      default: return w;
    endcase
  endfunction

  assign accept     = req_valid && req_ready;
  assign enter_resp = (state != RESP) && (state_n == RESP);

  assign req_err  = check_err(req_addr, req_size);
  assign wr_lanes = lane_mask(req_addr[1:0], req_size);
  assign wr_data  = lane_data(req_wdata, req_size);

  // With a one-cycle latency the response is formed on the accept edge itself,
  // before the latched copy exists, so read straight from the request bus then.
  assign sel_wr   = (state == IDLE) ? req_wr       : wr_p0;
  assign sel_addr = (state == IDLE) ? req_addr     : addr_p0;
  assign sel_size = (state == IDLE) ? req_size     : size_p0;
  assign sel_uns  = (state == IDLE) ? req_unsigned : uns_p0;
  assign sel_err  = check_err(sel_addr, sel_size);
  assign rd_word  = mem[sel_addr[AW+1:2]];

  always_comb begin
    state_n   = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = !rst;
        if (req_valid && !rst) begin
          state_n = LAT_ONE ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (cnt == 4'd1) begin
          state_n = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Control stage: FSM, latency counter and the registered response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        cnt <= CNT_LOAD;
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (enter_resp) begin
        rsp_err   <= sel_err;
        rsp_rdata <= (sel_wr || sel_err) ? 32'd0
                   : load_extend(rd_word, sel_addr[1:0], sel_size, sel_uns);
      end
    end
  end

  // Request latch stage p0.
  always_ff @(posedge clk) begin
    if (accept) begin
      wr_p0   <= req_wr;
      addr_p0 <= req_addr;
      size_p0 <= req_size;
      uns_p0  <= req_unsigned;
    end
  end

  always_ff @(posedge clk) begin
    if (accept && req_wr && !req_err) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_lanes[b]) begin
          mem[req_addr[AW+1:2]][b*8 +: 8] <= wr_data[b*8 +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, hand-written corner sequences and
// randomized traffic checked against a byte-addressed memory model.
module tb_dmem_responder;

  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wr = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks = 0;
  int failures = 0;

  logic [7:0] mb [DEPTH*4];

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t tbl[$];

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic model_err(input logic [31:0] a, input logic [1:0] s);
    if (s == 2'd3) return 1'b1;
    if (a >= 32'(DEPTH * 4)) return 1'b1;
    if (s == 2'd1 && (a % 2) != 0) return 1'b1;
    if (s == 2'd2 && (a % 4) != 0) return 1'b1;
    return 1'b0;
  endfunction

  // Applies one transaction to the model memory and returns the response it should produce.
  task automatic model_apply(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                             input logic [1:0] s, input logic u,
                             output logic [31:0] er, output logic ee);
    int n;
    logic [31:0] v;
    n  = 1 << s;
    ee = model_err(a, s);
    er = 32'd0;
    if (ee) return;
    if (wr) begin
      for (int k = 0; k < n; k++) mb[int'(a) + k] = wd[8*k +: 8];
      return;
    end
    v = 32'd0;
    for (int k = 0; k < n; k++) v[8*k +: 8] = mb[int'(a) + k];
    if (!u && s == 2'd0 && v[7])  v = v + 32'hFFFF_FF00;
    if (!u && s == 2'd1 && v[15]) v = v + 32'hFFFF_0000;
    er = v;
  endtask

  task automatic drive(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                       input logic [1:0] s, input logic u);
    req_valid = 1'b1; req_wr = wr; req_addr = a; req_wdata = wd;
    req_size = s; req_unsigned = u;
  endtask

  // Called #1 after an edge with the DUT idle; runs one full transaction.
  task automatic do_req(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [1:0] s, input logic u, input int hold,
                        output logic [31:0] rd, output logic er);
    int n;
    logic [31:0] held;
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    drive(wr, a, wd, s, u);
    tick();
    req_valid = 1'b0;
    req_wdata = $urandom;
    chk("req_ready_busy", 32'(req_ready), 32'd0);
    n = 1;
    while (!rsp_valid && n < 20) begin
      tick();
      n++;
    end
    chk("rsp_latency", 32'(n), 32'(LAT));
    held = rsp_rdata;
    for (int h = 0; h < hold; h++) begin
      tick();
      chk("rsp_hold_valid", 32'(rsp_valid), 32'd1);
      chk("rsp_hold_data", rsp_rdata, held);
    end
    rd = rsp_rdata;
    er = rsp_err;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", 32'(rsp_valid), 32'd0);
    chk("req_ready_after", 32'(req_ready), 32'd1);
  endtask

  task automatic add(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                     input logic [1:0] s, input logic u, input logic [31:0] er, input logic ee);
    vec_t v;
    v.wr = wr; v.addr = a; v.wdata = wd; v.size = s; v.uns = u;
    v.exp_rdata = er; v.exp_err = ee;
    tbl.push_back(v);
  endtask

  initial begin
    logic [31:0] rd, er_d, cap;
    logic        ee, er_e;
    int          sel, hold;
    logic        wr;
    logic [31:0] a, wd;
    logic [1:0]  s;
    logic        u;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("reset_rsp_err", 32'(rsp_err), 32'd0);
    rst = 1'b0;
    tick();
    chk("post_reset_ready", 32'(req_ready), 32'd1);

    // Seed the low 256 bytes so every model byte there is known.
    for (int i = 0; i < 64; i++) begin
      wd = {16'h1111, 16'(i * 4)};
      model_apply(1'b1, 32'(i * 4), wd, 2'd2, 1'b0, er_d, er_e);
      do_req(1'b1, 32'(i * 4), wd, 2'd2, 1'b0, 0, rd, ee);
    end

    add(1, 32'h10,   32'hDEADBEEF, 2, 0, 32'h0,         0);
    add(0, 32'h10,   32'h0,        2, 0, 32'hDEADBEEF,  0);
    add(1, 32'h13,   32'h80,       0, 0, 32'h0,         0);
    add(0, 32'h13,   32'h0,        0, 0, 32'hFFFFFF80,  0);
    add(0, 32'h13,   32'h0,        0, 1, 32'h00000080,  0);
    add(0, 32'h10,   32'h0,        2, 0, 32'h80ADBEEF,  0);
    add(0, 32'h12,   32'h0,        0, 0, 32'hFFFFFFAD,  0);
    add(0, 32'h10,   32'h0,        2, 1, 32'h80ADBEEF,  0);
    add(1, 32'h22,   32'h8001,     1, 0, 32'h0,         0);
    add(0, 32'h22,   32'h0,        1, 0, 32'hFFFF8001,  0);
    add(0, 32'h22,   32'h0,        1, 1, 32'h00008001,  0);
    add(0, 32'h20,   32'h0,        2, 0, 32'h80010020,  0);
    add(0, 32'h20,   32'h0,        1, 0, 32'h00000020,  0);
    add(0, 32'h11,   32'h0,        2, 0, 32'h0,         1);
    add(1, 32'h21,   32'hBEEF,     1, 0, 32'h0,         1);
    add(0, 32'h20,   32'h0,        2, 0, 32'h80010020,  0);
    add(0, 32'h23,   32'h0,        1, 0, 32'h0,         1);
    add(0, 32'h20,   32'h0,        3, 0, 32'h0,         1);
    add(1, 32'h20,   32'h55,       3, 0, 32'h0,         1);
    add(0, 32'h1000, 32'h0,        2, 0, 32'h0,         1);
    add(1, 32'h1000, 32'h1,        2, 0, 32'h0,         1);
    add(1, 32'hFFC,  32'h0BADF00D, 2, 0, 32'h0,         0);
    add(0, 32'hFFC,  32'h0,        2, 0, 32'h0BADF00D,  0);
    add(0, 32'hFFF,  32'h0,        0, 1, 32'h0000000B,  0);
    add(0, 32'hFFE,  32'h0,        1, 0, 32'h00000BAD,  0);

    foreach (tbl[i]) begin
      model_apply(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].size, tbl[i].uns, er_d, er_e);
      do_req(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].size, tbl[i].uns, 0, rd, ee);
      chk($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rdata);
      chk($sformatf("vec%0d_err", i), 32'(ee), 32'(tbl[i].exp_err));
    end

    // Backpressure: response held while the request bus is churned.
    model_apply(1'b0, 32'h10, 32'h0, 2'd2, 1'b0, er_d, er_e);
    drive(1'b0, 32'h10, 32'h0, 2'd2, 1'b0);
    tick();
    req_valid = 1'b0;
    sel = 1;
    while (!rsp_valid && sel < 20) begin
      tick();
      sel++;
    end
    chk("bp_latency", 32'(sel), 32'(LAT));
    cap = rsp_rdata;
    chk("bp_rdata", cap, er_d);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h30, $urandom, 2'd2, 1'b0);
      req_valid = i[0];
      tick();
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_stable", rsp_rdata, cap);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b1;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    chk("bp_ready_after", 32'(req_ready), 32'd1);
    chk("bp_valid_after", 32'(rsp_valid), 32'd0);
    model_apply(1'b0, 32'h30, 32'h0, 2'd2, 1'b0, er_d, er_e);
    do_req(1'b0, 32'h30, 32'h0, 2'd2, 1'b0, 0, rd, ee);
    chk("bp_not_written", rd, er_d);

    // Reset while waiting: store stays committed, no response appears.
    model_apply(1'b1, 32'h40, 32'h12345678, 2'd2, 1'b0, er_d, er_e);
    drive(1'b1, 32'h40, 32'h12345678, 2'd2, 1'b0);
    tick();
    req_valid = 1'b0;
    rst = 1'b1;
    tick();
    chk("midrst_ready_in_rst", 32'(req_ready), 32'd0);
    chk("midrst_valid_in_rst", 32'(rsp_valid), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("midrst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    chk("midrst_idle", 32'(req_ready), 32'd1);
    do_req(1'b0, 32'h40, 32'h0, 2'd2, 1'b0, 0, rd, ee);
    chk("midrst_committed", rd, 32'h12345678);
    chk("midrst_err", 32'(ee), 32'd0);
    model_apply(1'b0, 32'h40, 32'h0, 2'd2, 1'b0, er_d, er_e);

    // Randomized traffic against the byte model.
    for (int t = 0; t < 300; t++) begin
      wr  = ($urandom_range(0, 2) == 0);
      sel = $urandom_range(0, 9);
      s   = (sel < 3) ? 2'd0 : (sel < 6) ? 2'd1 : (sel < 9) ? 2'd2 : 2'd3;
      if ($urandom_range(0, 9) == 0) a = 32'h1000 + 32'($urandom_range(0, 4095));
      else                           a = 32'($urandom_range(0, 255));
      wd   = $urandom;
      u    = 1'($urandom_range(0, 1));
      hold = $urandom_range(0, 3);
      model_apply(wr, a, wd, s, u, er_d, er_e);
      do_req(wr, a, wd, s, u, hold, rd, ee);
      chk($sformatf("rand%0d_rdata", t), rd, er_d);
      chk($sformatf("rand%0d_err", t), 32'(ee), 32'(er_e));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
